// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register writeback stage: opcodes, load funct3
// encodings, FSM state encoding and default datapath widths.
package reg_writeback_pkg;

    localparam int RW_XLEN   = 32;
    localparam int RW_REG_AW = 5;
    localparam int CNT_W     = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/reg_writeback_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of a
// full memory word, sign- or zero-extends it, and flags illegal
// funct3/offset combinations. Kept standalone so the LSU can reuse it.
module load_align
    import reg_writeback_pkg::*;
#(
    parameter int XLEN = RW_XLEN
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] aligned,
    output logic            legal
);

    logic signed [7:0]  byte_v;
    logic signed [15:0] half_v;

    // Lane select, then extension chosen by funct3
    always_comb begin
        byte_v  = '0;
        half_v  = '0;
        aligned = '0;
        legal   = 1'b0;
        case (offset)
            2'd0:    byte_v = data[7:0];
            2'd1:    byte_v = data[15:8];
            2'd2:    byte_v = data[23:16];
            default: byte_v = data[31:24];
        endcase
        half_v = offset[1] ? data[31:16] : data[15:0];
        case (funct3)
            F3_LB: begin
                aligned = {{(XLEN-8){byte_v[7]}}, byte_v};
                legal   = 1'b1;
            end
            F3_LBU: begin
                aligned = {{(XLEN-8){1'b0}}, byte_v};
                legal   = 1'b1;
            end
            F3_LH: begin
                aligned = {{(XLEN-16){half_v[15]}}, half_v};
                legal   = ~offset[0];
            end
            F3_LHU: begin
                aligned = {{(XLEN-16){1'b0}}, half_v};
                legal   = ~offset[0];
            end
            F3_LW: begin
                aligned = data;
                legal   = (offset == 2'd0);
            end
            default: begin
                aligned = '0;
                legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: retires execute results into the register file, runs the
// load request/response handshake with data memory, and stalls the pipeline
// while a load is outstanding. Every register-file output is a flop.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int XLEN        = RW_XLEN,
    parameter int REG_AW      = RW_REG_AW,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [6:0]        ex_opcode,
    input  logic [2:0]        ex_funct3,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    output logic              mem_req_valid,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   write_data,
    output logic              write_en,
    output logic              halt,
    output logic              load_err
);

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [2:0]        al_f3;
    logic [1:0]        al_off;
    logic [XLEN-1:0]   al_data;
    logic              al_legal;

    // In IDLE the aligner judges the incoming load; afterwards it decodes
    // the response using the fields captured at acceptance.
    assign al_f3  = (state_q == ST_IDLE) ? ex_funct3       : f3_q;
    assign al_off = (state_q == ST_IDLE) ? ex_result[1:0]  : off_q;

    load_align #(.XLEN(XLEN)) u_align (
        .data    (mem_rsp_data),
        .offset  (al_off),
        .funct3  (al_f3),
        .aligned (al_data),
        .legal   (al_legal)
    );

    // Next-state and next-output logic for the IDLE/REQ/WAIT handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_opcode == OP_LOAD) begin
                        rd_d   = ex_rd;
                        f3_d   = ex_funct3;
                        off_d  = ex_result[1:0];
                        addr_d = {ex_result[XLEN-1:2], 2'b00};
                        if (al_legal) begin
                            state_d = ST_REQ;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (ex_opcode != OP_STORE && ex_opcode != OP_BRANCH
                                 && ex_rd != '0) begin
                        we_d    = 1'b1;
                        waddr_d = ex_rd;
                        wdata_d = ex_result;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the last allowed cycle still wins
                if (mem_rsp_valid) begin
                    state_d = ST_IDLE;
                    if (rd_q != '0) begin
                        we_d    = 1'b1;
                        waddr_d = rd_q;
                        wdata_d = al_data;
                    end
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any load in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign ex_ready      = (state_q == ST_IDLE);
    assign halt          = (state_q != ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = addr_q;
    assign rd_addr       = waddr_q;
    assign write_data    = wdata_q;
    assign write_en      = we_q;
    assign load_err      = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed and randomized ALU ops and
// loads compared against a plain-arithmetic model of the writeback rules.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic        write_en;
    logic        halt;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rd_addr       (rd_addr),
        .write_data    (write_data),
        .write_en      (write_en),
        .halt          (halt),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: what a load of funct3 at byte offset off returns from word d
    function automatic void model_load(input logic [2:0] f3, input logic [1:0] off,
                                       input logic [31:0] d, output bit ok,
                                       output logic [31:0] v);
        int unsigned b;
        int unsigned h;
        b  = (d >> (8 * off)) & 32'hFF;
        h  = (d >> (16 * (off / 2))) & 32'hFFFF;
        ok = 1'b0;
        v  = 32'h0;
        case (f3)
            3'd0: begin ok = 1'b1; v = (b >= 128) ? 32'(int'(b) - 256) : b; end
            3'd4: begin ok = 1'b1; v = b; end
            3'd1: begin ok = (off % 2 == 0); v = (h >= 32768) ? 32'(int'(h) - 65536) : h; end
            3'd5: begin ok = (off % 2 == 0); v = h; end
            3'd2: begin ok = (off == 0); v = d; end
            default: ok = 1'b0;
        endcase
    endfunction

    // Issue one non-load instruction and check the following cycle
    task automatic alu_op(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] res);
        bit wr;
        wr = (rd != 0) && (op != 7'b0100011) && (op != 7'b1100011);
        ex_valid = 1'b1; ex_opcode = op; ex_funct3 = 3'($urandom_range(0, 7));
        ex_rd = rd; ex_result = res;
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", ex_ready); end
        tick;
        ex_valid = 1'b0;
        n_checks++; if (write_en !== wr) begin n_fail++; $display("FAIL alu_write_en op=%h rd=%0d: got %b want %b", op, rd, write_en, wr); end
        if (wr) begin
            n_checks++; if (rd_addr !== rd) begin n_fail++; $display("FAIL alu_rd_addr: got %0d want %0d", rd_addr, rd); end
            n_checks++; if (write_data !== res) begin n_fail++; $display("FAIL alu_write_data: got %h want %h", write_data, res); end
        end
        n_checks++; if (halt !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL alu_halt_err: got %b%b want 00", halt, load_err); end
    endtask

    // Run one load; rsp_at = WAIT cycle (1..15) carrying the response, 0 = none
    task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] data, input int ready_dly, input int rsp_at);
        bit          ok;
        logic [31:0] expv;
        model_load(f3, addr[1:0], data, ok, expv);
        ex_valid = 1'b1; ex_opcode = 7'b0000011; ex_funct3 = f3; ex_rd = rd; ex_result = addr;
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL ld_accept_ready: got %b want 1", ex_ready); end
        tick;
        ex_valid = 1'b0; ex_result = $urandom;
        if (!ok) begin
            n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL ld_illegal_err f3=%0d addr=%h: got %b want 1", f3, addr, load_err); end
            n_checks++; if (mem_req_valid !== 1'b0 || write_en !== 1'b0 || halt !== 1'b0) begin n_fail++; $display("FAIL ld_illegal_quiet: got req=%b we=%b halt=%b want 000", mem_req_valid, write_en, halt); end
            tick;
            n_checks++; if (load_err !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL ld_illegal_after: got err=%b req=%b want 00", load_err, mem_req_valid); end
            return;
        end
        n_checks++; if (load_err !== 1'b0 || write_en !== 1'b0) begin n_fail++; $display("FAIL ld_req_quiet: got err=%b we=%b want 00", load_err, write_en); end
        for (int i = 0; i < ready_dly; i++) begin
            n_checks++; if (mem_req_valid !== 1'b1 || halt !== 1'b1 || ex_ready !== 1'b0) begin n_fail++; $display("FAIL ld_req_hold: got req=%b halt=%b rdy=%b want 110", mem_req_valid, halt, ex_ready); end
            n_checks++; if (mem_req_addr !== (addr & ~32'h3)) begin n_fail++; $display("FAIL ld_req_addr_hold: got %h want %h", mem_req_addr, addr & ~32'h3); end
            mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
            tick;
            mem_rsp_valid = 1'b0;
        end
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL ld_req_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== (addr & ~32'h3)) begin n_fail++; $display("FAIL ld_req_addr: got %h want %h", mem_req_addr, addr & ~32'h3); end
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            n_checks++; if (halt !== 1'b1 || mem_req_valid !== 1'b0 || write_en !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL ld_wait_%0d: got halt=%b req=%b we=%b err=%b want 1000", k, halt, mem_req_valid, write_en, load_err); end
            if (k == rsp_at) begin mem_rsp_valid = 1'b1; mem_rsp_data = data; end
            tick;
            mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
            if (k == rsp_at) break;
        end
        if (rsp_at >= 1 && rsp_at <= 15) begin
            n_checks++; if (write_en !== (rd != 0)) begin n_fail++; $display("FAIL ld_write_en rd=%0d: got %b want %b", rd, write_en, rd != 0); end
            if (rd != 0) begin
                n_checks++; if (rd_addr !== rd) begin n_fail++; $display("FAIL ld_rd_addr: got %0d want %0d", rd_addr, rd); end
                n_checks++; if (write_data !== expv) begin n_fail++; $display("FAIL ld_write_data f3=%0d addr=%h rsp=%h: got %h want %h", f3, addr, data, write_data, expv); end
            end
            n_checks++; if (halt !== 1'b0 || ex_ready !== 1'b1 || load_err !== 1'b0) begin n_fail++; $display("FAIL ld_done: got halt=%b rdy=%b err=%b want 010", halt, ex_ready, load_err); end
        end else begin
            n_checks++; if (load_err !== 1'b1 || write_en !== 1'b0) begin n_fail++; $display("FAIL ld_timeout: got err=%b we=%b want 10", load_err, write_en); end
            n_checks++; if (halt !== 1'b0 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL ld_timeout_idle: got halt=%b rdy=%b want 01", halt, ex_ready); end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_rd = '0; ex_result = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick; tick;
        rst = 1'b0;
        n_checks++; if (write_en !== 1'b0 || load_err !== 1'b0 || halt !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got we=%b err=%b halt=%b req=%b want 0000", write_en, load_err, halt, mem_req_valid); end
        n_checks++; if (rd_addr !== 5'd0 || write_data !== 32'd0 || mem_req_addr !== 32'd0) begin n_fail++; $display("FAIL reset_data: got rd=%0d wd=%h addr=%h want 0", rd_addr, write_data, mem_req_addr); end
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ex_ready); end
    endtask

    task automatic test_alu;
        logic [6:0] op;
        alu_op(7'b0110011, 5'd5, 32'h1234_5678);
        alu_op(7'b0110011, 5'd0, 32'hCAFE_F00D);
        alu_op(7'b0100011, 5'd6, 32'h0000_1111);
        alu_op(7'b1100011, 5'd7, 32'h0000_2222);
        for (int i = 0; i < 10; i++) begin
            op = 7'($urandom);
            if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011) op = 7'b0010011;
            alu_op(op, 5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  rd;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            rd = 5'($urandom_range(1, 31)); res = $urandom;
            ex_valid = 1'b1; ex_opcode = 7'b0110011; ex_rd = rd; ex_result = res;
            tick;
            n_checks++; if (write_en !== 1'b1 || rd_addr !== rd || write_data !== res) begin n_fail++; $display("FAIL b2b_%0d: got we=%b rd=%0d wd=%h want 1 %0d %h", i, write_en, rd_addr, write_data, rd, res); end
        end
        ex_valid = 1'b0;
        tick;
        n_checks++; if (write_en !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", write_en); end
    endtask

    task automatic test_directed_loads;
        do_load(3'd0, 5'd7,  32'h0000_0103, 32'h8012_3456, 0, 1);
        do_load(3'd4, 5'd8,  32'h0000_0103, 32'h8012_3456, 1, 2);
        do_load(3'd1, 5'd9,  32'h0000_0102, 32'hBEEF_0000, 0, 1);
        do_load(3'd1, 5'd9,  32'h0000_0101, 32'hBEEF_0000, 0, 1);
        do_load(3'd2, 5'd10, 32'h0000_0200, 32'hDEAD_BEEF, 4, 3);
        alu_op(7'b0110011, 5'd11, 32'h0BAD_CAFE);
        do_load(3'd2, 5'd0,  32'h0000_0204, 32'h1111_2222, 0, 1);
        do_load(3'd3, 5'd12, 32'h0000_0300, 32'h0, 0, 1);
        do_load(3'd6, 5'd12, 32'h0000_0300, 32'h0, 0, 1);
        do_load(3'd2, 5'd13, 32'h0000_0302, 32'h0, 0, 1);
    endtask

    task automatic test_timeout;
        do_load(3'd2, 5'd14, 32'h0000_0400, 32'h5555_AAAA, 0, 0);
        do_load(3'd2, 5'd15, 32'h0000_0404, 32'h1357_9BDF, 2, 15);
        do_load(3'd5, 5'd16, 32'h0000_0406, 32'h8001_7FFF, 0, 14);
    endtask

    task automatic test_reset_mid_load;
        ex_valid = 1'b1; ex_opcode = 7'b0000011; ex_funct3 = 3'd2; ex_rd = 5'd20; ex_result = 32'h0000_0500;
        tick;
        ex_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (halt !== 1'b0 || ex_ready !== 1'b1 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got halt=%b rdy=%b req=%b want 010", halt, ex_ready, mem_req_valid); end
        n_checks++; if (write_en !== 1'b0 || load_err !== 1'b0 || rd_addr !== 5'd0 || write_data !== 32'd0) begin n_fail++; $display("FAIL midrst_outputs: got we=%b err=%b rd=%0d wd=%h want 0", write_en, load_err, rd_addr, write_data); end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        tick;
        mem_rsp_valid = 1'b0;
        n_checks++; if (write_en !== 1'b0 || load_err !== 1'b0 || halt !== 1'b0) begin n_fail++; $display("FAIL midrst_late_rsp: got we=%b err=%b halt=%b want 000", write_en, load_err, halt); end
    endtask

    task automatic test_random_loads;
        int rsp_at;
        for (int i = 0; i < 24; i++) begin
            rsp_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 15);
            do_load(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                    $urandom_range(0, 3), rsp_at);
            if ($urandom_range(0, 1) == 1) alu_op(7'b0110011, 5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_back_to_back;
        test_directed_loads;
        test_timeout;
        test_reset_mid_load;
        test_random_loads;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage that produces the write side of the system register-file interface: it takes completed execute-stage results, runs the load handshake with data memory, aligns and sign-extends load data by funct3, and drives one registered destination write (`rd_addr`, `write_data`, `write_en`) per instruction. While a load is outstanding it asserts `halt` to freeze fetch and execute, so register reads never overtake a pending write.

## Interface
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register address width (32 registers)
- `MEM_TIMEOUT`, 15, max cycles in WAIT before a load is abandoned (4-bit counter)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `ex_valid`  in  1  execute result valid
- `ex_ready`  out  1  stage can accept (high only in IDLE)
- `ex_opcode`  in  7  instruction opcode
- `ex_funct3`  in  3  instruction funct3
- `ex_rd`  in  REG_AW  destination register
- `ex_result`  in  XLEN  ALU result, or effective address for loads
- `mem_req_valid`  out  1  load request valid
- `mem_req_addr`  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- `mem_req_ready`  in  1  memory accepts request
- `mem_rsp_valid`  in  1  read data valid (single-cycle pulse)
- `mem_rsp_data`  in  XLEN  full read word
- `rd_addr`  out  REG_AW  register write address
- `write_data`  out  XLEN  register write data
- `write_en`  out  1  register write strobe (one cycle)
- `halt`  out  1  pipeline stall while a load is pending
- `load_err`  out  1  one-cycle pulse: misaligned load, bad funct3, or timeout

## Operation
- States: IDLE, REQ, WAIT. Reset -> IDLE; all outputs 0, timeout counter 0, captured rd/funct3/offset cleared.
- Handshake: transfer when `ex_valid && ex_ready`.
- Non-load, opcode not STORE/BRANCH: next cycle `write_en`=1, `rd_addr`=ex_rd, `write_data`=ex_result; remain IDLE.
- STORE, BRANCH: accepted, no write.
- `ex_rd`==0: never write (x0 stays 0), for every opcode including loads.
- LOAD: capture rd, funct3, addr[1:0]; check alignment/funct3 at acceptance:
  - LB/LBU: any offset; LH/LHU: addr[0]==0; LW: addr[1:0]==0; funct3 011/110/111 illegal.
  - Failure: `load_err` pulse next cycle, no memory request, stay IDLE.
  - Success: -> REQ.
- REQ: `mem_req_valid`=1, address held stable until `mem_req_ready`; then -> WAIT, counter cleared.
- WAIT: counter increments each cycle. On `mem_rsp_valid`: extract byte `data[8*off+:8]` / half `data[16*off[1]+:16]` / word, sign-extend (LB/LH) or zero-extend (LBU/LHU), write next cycle, -> IDLE. If counter reaches MEM_TIMEOUT first: `load_err` pulse, no write, -> IDLE.
- `mem_rsp_valid` outside WAIT is ignored.
- `halt` = (state != IDLE).
- Reset mid-load: abandon immediately, no write, no err pulse; a late response is ignored.

## Timing
- ALU op accepted cycle N -> `write_en` at N+1.
- Load accepted N -> `mem_req_valid` from N+1; ready at cycle R -> WAIT at R+1; response at M -> `write_en` and return to IDLE (`ex_ready`=1) at M+1. Minimum load latency is 3 cycles (ready at N+1, response at N+2).
- `mem_rsp_valid` in the same cycle the counter hits MEM_TIMEOUT: the response wins.
- `halt` falls in the same cycle the load writeback strobes.
- All outputs are registered; no combinational path from `mem_*` inputs to register-file outputs.

## Structure
- Shared package/header: opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011), funct3 load encodings, state encoding, XLEN, register address width.
- One sub-module: `load_align` (combinational: data, offset, funct3 -> aligned XLEN value plus legal flag), reused later by the LSU.

## Test plan
- ALU op: rd=5, result 0x1234_5678 at N -> N+1 `write_en`=1, `rd_addr`=5, `write_data`=0x12345678; rd=0 -> no write.
- LB at addr 0x103, rsp 0x80xx_xxxx -> `mem_req_addr`=0x100, write 0xFFFF_FF80; LBU same -> 0x0000_0080.
- LH at 0x102, rsp 0xBEEF_0000 -> 0xFFFF_BEEF; LH at 0x101 -> `load_err` at N+1, `mem_req_valid` never asserted.
- `mem_req_ready` held low 4 cycles -> address stable and `halt`=1 throughout; LW rsp 0xDEAD_BEEF -> write 0xDEADBEEF, `ex_ready`=1 the same cycle.
- No response -> `load_err` after 15 WAIT cycles, no write; response coincident with cycle 15 -> write occurs, no error.
- `rst` in WAIT, then a response -> outputs 0, no write, state IDLE.
